// File: rtl/approx_div_err_accum_pkg.sv
// rtl/approx_div_err_accum_pkg.sv - shared constants, FSM state codes and saturating add
// Sized for the 16/8 approximate array dividers this monitor sits behind.
package div_err_pkg;

  localparam int N_W  = 16;
  localparam int D_W  = 8;
  localparam int ITER = 8;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t DIV  = 2'd1;
  localparam state_t ACC  = 2'd2;

  // Clamps a + b to the all-ones value of a w-bit field (w <= 63).
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [63:0] lim;
    logic [63:0] s;
    lim = (64'd1 << w) - 64'd1;
    s   = a + b;
    return (s > lim) ? lim : s;
  endfunction

endpackage

// File: rtl/approx_div_err_accum_if.sv
// rtl/approx_div_err_accum_if.sv - sample handshake carrying divider operands and approximate results
// The master is the divider side offering samples; the slave is the error monitor.
interface approx_div_err_accum_if;
  import div_err_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [N_W-1:0] n;
  logic [D_W-1:0] d;
  logic [D_W-1:0] q_apx;
  logic [D_W-1:0] r_apx;

  modport master (output in_valid, n, d, q_apx, r_apx, input in_ready);
  modport slave  (input in_valid, n, d, q_apx, r_apx, output in_ready);
endinterface

// File: rtl/approx_div_err_accum_div.sv
// rtl/approx_div_err_accum_div.sv - 8-cycle restoring divider, MSB first, producing the exact reference
// Caller guarantees n[15:8] < d, so the partial remainder always fits 8 bits between iterations.
module restoring_div_seq
  import div_err_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           abort,
  input  logic           start,
  input  logic [N_W-1:0] n,
  input  logic [D_W-1:0] d,
  output logic           busy,
  output logic           done,
  output logic [D_W-1:0] q_exact,
  output logic [D_W-1:0] r_exact
);

  logic [D_W-1:0] rem_q, rem_d;
  logic [D_W-1:0] nlo_q, nlo_d;
  logic [D_W-1:0] quo_q, quo_d;
  logic [D_W-1:0] dv_q, dv_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic [D_W:0]   rem_sh;
  logic           ge;

  always_comb begin
    rem_d  = rem_q;
    nlo_d  = nlo_q;
    quo_d  = quo_q;
    dv_d   = dv_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    rem_sh = {rem_q, nlo_q[D_W-1]};
    ge     = rem_sh >= {1'b0, dv_q};
    if (abort) begin
      busy_d = 1'b0;
    end else if (start) begin
      rem_d  = n[N_W-1:D_W];
      nlo_d  = n[D_W-1:0];
      dv_d   = d;
      quo_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = ge ? D_W'(rem_sh - {1'b0, dv_q}) : rem_sh[D_W-1:0];
      quo_d = {quo_q[D_W-2:0], ge};
      nlo_d = {nlo_q[D_W-2:0], 1'b0};
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'(ITER - 1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      nlo_q  <= '0;
      quo_q  <= '0;
      dv_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      nlo_q  <= nlo_d;
      quo_q  <= quo_d;
      dv_q   <= dv_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == 3'(ITER - 1));
  assign q_exact = quo_q;
  assign r_exact = rem_q;

endmodule

// File: rtl/approx_div_err_accum.sv
// rtl/approx_div_err_accum.sv - accumulates squared/max quotient error of approximate dividers
// DIV_ERR_REM_EN adds the sse_r port and remainder squared-error accumulator.
module approx_div_err_accum
  import div_err_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int SSE_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  approx_div_err_accum_if.slave  s_in,
  output logic [CNT_W-1:0]       sample_cnt,
  output logic [CNT_W-1:0]       ovf_cnt,
  output logic [SSE_W-1:0]       sse_q,
`ifdef DIV_ERR_REM_EN
  output logic [SSE_W-1:0]       sse_r,
`endif
  output logic [D_W-1:0]         max_err_q,
  output logic                   sat
);

  state_t         state_q, state_d;
  logic           ovf_q, ovf_d;
  logic [D_W-1:0] qa_q, qa_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d, ovf_cnt_q, ovf_cnt_d;
  logic [SSE_W-1:0] sse_q_q, sse_q_d;
  logic [D_W-1:0]   max_err_q_q, max_err_q_d;
  logic           is_ovf, start, div_busy, div_done;
  logic [D_W-1:0] q_exact, r_exact;
  logic [D_W:0]   e_q;
  logic [D_W-1:0] ae_q;
  logic [15:0]    e2_q;

  // Anything the 8-bit array cannot represent is counted, never divided.
  assign is_ovf = (s_in.d == '0) || (s_in.n[N_W-1:D_W] >= s_in.d);
  assign start  = (state_q == IDLE) && s_in.in_valid && !clear && !is_ovf;
  assign s_in.in_ready = (state_q == IDLE);
  assign sat    = &sample_cnt_q;

  restoring_div_seq u_div (
    .clk     (clk),
    .rst     (rst),
    .abort   (clear),
    .start   (start),
    .n       (s_in.n),
    .d       (s_in.d),
    .busy    (div_busy),
    .done    (div_done),
    .q_exact (q_exact),
    .r_exact (r_exact)
  );

  assign e_q  = {1'b0, q_exact} - {1'b0, qa_q};
  assign ae_q = e_q[D_W] ? (~e_q[D_W-1:0] + 8'd1) : e_q[D_W-1:0];
  assign e2_q = {8'd0, ae_q} * {8'd0, ae_q};

`ifdef DIV_ERR_REM_EN
  logic [D_W-1:0]   ra_q, ra_d;
  logic [SSE_W-1:0] sse_r_q, sse_r_d;
  logic [D_W:0]     e_r;
  logic [D_W-1:0]   ae_r;
  logic [15:0]      e2_r;
  assign e_r  = {1'b0, r_exact} - {1'b0, ra_q};
  assign ae_r = e_r[D_W] ? (~e_r[D_W-1:0] + 8'd1) : e_r[D_W-1:0];
  assign e2_r = {8'd0, ae_r} * {8'd0, ae_r};
  assign sse_r = sse_r_q;
`else
  logic unused_rem;
  assign unused_rem = ^{r_exact, s_in.r_apx, div_busy};
`endif

  always_comb begin
    state_d      = state_q;
    ovf_d        = ovf_q;
    qa_d         = qa_q;
    sample_cnt_d = sample_cnt_q;
    ovf_cnt_d    = ovf_cnt_q;
    sse_q_d      = sse_q_q;
    max_err_q_d  = max_err_q_q;
`ifdef DIV_ERR_REM_EN
    ra_d    = ra_q;
    sse_r_d = sse_r_q;
`endif
    if (clear) begin
      state_d      = IDLE;
      sample_cnt_d = '0;
      ovf_cnt_d    = '0;
      sse_q_d      = '0;
      max_err_q_d  = '0;
`ifdef DIV_ERR_REM_EN
      sse_r_d = '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (s_in.in_valid) begin
          state_d = is_ovf ? ACC : DIV;
          ovf_d   = is_ovf;
          qa_d    = s_in.q_apx;
`ifdef DIV_ERR_REM_EN
          ra_d    = s_in.r_apx;
`endif
        end
        DIV: if (div_done) state_d = ACC;
        ACC: begin
          state_d = IDLE;
          if (!sat) begin
            if (ovf_q) begin
              ovf_cnt_d = CNT_W'(sat_add(64'(ovf_cnt_q), 64'd1, CNT_W));
            end else begin
              sample_cnt_d = CNT_W'(sat_add(64'(sample_cnt_q), 64'd1, CNT_W));
              sse_q_d      = SSE_W'(sat_add(64'(sse_q_q), 64'(e2_q), SSE_W));
              if (ae_q > max_err_q_q) max_err_q_d = ae_q;
`ifdef DIV_ERR_REM_EN
              sse_r_d = SSE_W'(sat_add(64'(sse_r_q), 64'(e2_r), SSE_W));
`endif
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ovf_q        <= 1'b0;
      qa_q         <= '0;
      sample_cnt_q <= '0;
      ovf_cnt_q    <= '0;
      sse_q_q      <= '0;
      max_err_q_q  <= '0;
`ifdef DIV_ERR_REM_EN
      ra_q    <= '0;
      sse_r_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ovf_q        <= ovf_d;
      qa_q         <= qa_d;
      sample_cnt_q <= sample_cnt_d;
      ovf_cnt_q    <= ovf_cnt_d;
      sse_q_q      <= sse_q_d;
      max_err_q_q  <= max_err_q_d;
`ifdef DIV_ERR_REM_EN
      ra_q    <= ra_d;
      sse_r_q <= sse_r_d;
`endif
    end
  end

  assign sample_cnt = sample_cnt_q;
  assign ovf_cnt    = ovf_cnt_q;
  assign sse_q      = sse_q_q;
  assign max_err_q  = max_err_q_q;

endmodule

// File: tb/tb_approx_div_err_accum.sv
// tb/tb_approx_div_err_accum.sv - directed self-checking bench for approx_div_err_accum
// Counters are narrowed to 4 bits so saturation is reachable in a short run.
module tb_approx_div_err_accum;

  localparam int CNT_W = 4;
  localparam int SSE_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  logic [CNT_W-1:0] sample_cnt, ovf_cnt;
  logic [SSE_W-1:0] sse_q;
`ifdef DIV_ERR_REM_EN
  logic [SSE_W-1:0] sse_r;
`endif
  logic [7:0] max_err_q;
  logic       sat;

  int n_cmp = 0;
  int n_mis = 0;
  int lat;
  int acc_n;
  int busy_n;

  always #5 clk = ~clk;

  approx_div_err_accum_if u_if ();

  approx_div_err_accum #(.CNT_W(CNT_W), .SSE_W(SSE_W)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .s_in       (u_if.slave),
    .sample_cnt (sample_cnt),
    .ovf_cnt    (ovf_cnt),
    .sse_q      (sse_q),
`ifdef DIV_ERR_REM_EN
    .sse_r      (sse_r),
`endif
    .max_err_q  (max_err_q),
    .sat        (sat)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offers one sample on the next edge; lat counts edges after accept until in_ready returns.
  task automatic send(input logic [15:0] n, input logic [7:0] d, input logic [7:0] qa,
                      input logic [7:0] ra, output int lat_o);
    u_if.in_valid = 1'b1;
    u_if.n = n; u_if.d = d; u_if.q_apx = qa; u_if.r_apx = ra;
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    u_if.n = 16'hFFFF; u_if.d = 8'h01; u_if.q_apx = 8'hAA; u_if.r_apx = 8'h55;
    lat_o = 0;
    while (!u_if.in_ready && lat_o < 20) begin
      @(posedge clk); #1;
      lat_o++;
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0;
    u_if.in_valid = 1'b0; u_if.n = '0; u_if.d = '0; u_if.q_apx = '0; u_if.r_apx = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ready", u_if.in_ready, 1);
    check("rst_cnt", sample_cnt, 0);
    check("rst_ovf", ovf_cnt, 0);
    check("rst_sse", sse_q, 0);
    check("rst_max", max_err_q, 0);
    check("rst_sat", sat, 0);

    send(16'd100, 8'd7, 8'd14, 8'd2, lat);
    check("t1_lat", lat, 9);
    check("t1_cnt", sample_cnt, 1);
    check("t1_sse", sse_q, 0);
    check("t1_max", max_err_q, 0);
`ifdef DIV_ERR_REM_EN
    check("t1_sse_r", sse_r, 0);
`endif

    send(16'd100, 8'd7, 8'd12, 8'd16, lat);
    check("t2_cnt", sample_cnt, 2);
    check("t2_sse", sse_q, 4);
    check("t2_max", max_err_q, 2);
`ifdef DIV_ERR_REM_EN
    check("t2_sse_r", sse_r, 196);
`endif

    send(16'h0800, 8'd8, 8'd0, 8'd0, lat);
    check("ovf1_lat", lat, 1);
    check("ovf1_cnt", ovf_cnt, 1);
    send(16'h1234, 8'd0, 8'd0, 8'd0, lat);
    check("ovf0_lat", lat, 1);
    check("ovf0_cnt", ovf_cnt, 2);
    check("ovf_samples", sample_cnt, 2);
    check("ovf_sse", sse_q, 4);

    // 12345/200 = 61 r145; q_apx 70 gives e=-9
    send(16'd12345, 8'd200, 8'd70, 8'd145, lat);
    check("t3_cnt", sample_cnt, 3);
    check("t3_sse", sse_q, 85);
    check("t3_max", max_err_q, 9);
    // smaller error must not lower the maximum
    send(16'd1000, 8'd10, 8'd99, 8'd0, lat);
    check("t4_sse", sse_q, 86);
    check("t4_max", max_err_q, 9);
    // 65279/255 = 255 r254; q_apx 0 is the largest possible |e|
    send(16'hFEFF, 8'hFF, 8'd0, 8'd254, lat);
    check("t5_sse", sse_q, 65111);
    check("t5_max", max_err_q, 255);
`ifdef DIV_ERR_REM_EN
    check("t5_sse_r", sse_r, 196);
`endif

    u_if.in_valid = 1'b1;
    u_if.n = 16'd100; u_if.d = 8'd7; u_if.q_apx = 8'd14; u_if.r_apx = 8'd2;
    acc_n = 0; busy_n = 0;
    for (int i = 0; i < 30; i++) begin
      if (u_if.in_ready) acc_n++; else busy_n++;
      @(posedge clk); #1;
    end
    u_if.in_valid = 1'b0;
    check("stream_accepts", acc_n, 3);
    check("stream_busy", busy_n, 27);
    check("stream_cnt", sample_cnt, 8);
    check("stream_ready", u_if.in_ready, 1);

    u_if.in_valid = 1'b1;
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr_ready", u_if.in_ready, 1);
    check("clr_cnt", sample_cnt, 0);
    check("clr_sse", sse_q, 0);
    check("clr_max", max_err_q, 0);
    check("clr_ovf", ovf_cnt, 0);
    repeat (12) @(posedge clk);
    #1 check("clr_aborted", sample_cnt, 0);

    clear = 1'b1; u_if.in_valid = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; u_if.in_valid = 1'b0;
    check("clr_wins_ready", u_if.in_ready, 1);
    repeat (12) @(posedge clk);
    #1 check("clr_wins_cnt", sample_cnt, 0);

    // q_exact=14, q_apx=14^0xFF=241: |e|=227, e^2=51529
    for (int i = 0; i < 15; i++) send(16'd100, 8'd7, 8'hF1, 8'd2, lat);
    check("sat_flag", sat, 1);
    check("sat_cnt", sample_cnt, 15);
    check("sat_sse", sse_q, 772935);
    check("sat_max", max_err_q, 227);
    send(16'd1000, 8'd10, 8'd0, 8'd0, lat);
    check("sat_lat", lat, 9);
    send(16'h0800, 8'd8, 8'd0, 8'd0, lat);
    check("sat_hold_cnt", sample_cnt, 15);
    check("sat_hold_sse", sse_q, 772935);
    check("sat_hold_max", max_err_q, 227);
    check("sat_hold_ovf", ovf_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/approx_div_err_accum.md
# approx_div_err_accum

Sequential error monitor placed directly downstream of the 16/8 approximate array dividers. It consumes each dividend and divisor together with the approximate quotient and remainder that the divider produced for them. It recomputes the exact result with an iterative restoring divider and accumulates squared quotient error, maximum absolute error and sample counts. These statistics are the area-vs-MSE figures of merit that the heuristic flow reads back.

## Interface
Parameters:
- CNT_W, 16: width of the sample and overflow counters.
- SSE_W, 32: width of the sum-of-squared-error accumulators.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-high reset.
- clear  in  1  synchronous clear of all statistics; aborts any in-flight sample.
- in_valid  in  1  sample offered.
- in_ready  out  1  block can accept a sample.
- n  in  16  dividend given to the divider.
- d  in  8  divisor given to the divider.
- q_apx  in  8  approximate quotient from the divider.
- r_apx  in  8  approximate remainder from the divider.
- sample_cnt  out  CNT_W  number of accumulated samples (saturating).
- ovf_cnt  out  CNT_W  number of rejected samples (saturating).
- sse_q  out  SSE_W  sum of (q_exact − q_apx)².
- sse_r  out  SSE_W  sum of (r_exact − r_apx)²; only present with DIV_ERR_REM_EN.
- max_err_q  out  8  largest |q_exact − q_apx| seen.
- sat  out  1  sample_cnt has reached all-ones; further samples are ignored.

## Operation
- States:
  - IDLE: in_ready=1.
  - DIV: 8 iterations.
  - ACC: 1 cycle.
- Transitions:
  - IDLE→DIV on in_valid && in_ready. The accepted sample is latched.
  - DIV→ACC after iteration 7.
  - ACC→IDLE unconditionally.
- Overflow and divide-by-zero: a sample with d==0 or n[15:8] ≥ d cannot be represented by the 8-bit array.
  - It is accepted and goes IDLE→ACC directly, skipping DIV.
  - In ACC only ovf_cnt increments.
- Exact division is restoring, MSB first, with a 9-bit partial remainder.
  - Initial partial remainder is n[15:8].
  - Per iteration: shift in the next n bit, subtract d, keep the result if non-negative, and shift a quotient bit in.
  - Results: q_exact is 8 bits, r_exact is 8 bits.
- Error arithmetic in ACC:
  - e = q_exact − q_apx as 9-bit signed.
  - |e| ≤ 255, and e² (16-bit unsigned) is added to sse_q.
  - max_err_q = max(max_err_q, |e|).
  - sample_cnt increments.
- Saturation: sse and counters saturate at all-ones and never wrap. When sat=1, ACC performs no updates, but in_ready behaviour is unchanged so the upstream never stalls.
- Statistics outputs are registered and change only in the ACC cycle, on clear, or on rst.

## Timing
- Reset value: all outputs 0, except in_ready=1 in the cycle after rst deasserts. State is IDLE.
- Handshake: a transfer occurs on a rising edge with in_valid && in_ready. in_ready is deasserted from the following cycle until the block returns to IDLE.
- Latency:
  - Valid sample: accept at edge 0, DIV covers edges 1–8, ACC update visible after edge 9, in_ready=1 again after edge 9. Throughput is 1 sample per 10 cycles.
  - Overflow sample: update visible after edge 1, in_ready=1 after edge 1.
- clear:
  - Zeroes all statistics at the edge and forces IDLE; the in-flight sample is discarded.
  - clear && in_valid in IDLE: clear wins and no sample is accepted.
  - rst has priority over clear.
- Inputs n, d, q_apx and r_apx need only be stable in the accept cycle.

## Configuration
- DIV_ERR_REM_EN defined:
  - The sse_r port exists.
  - ACC also adds (r_exact − r_apx)², computed as 9-bit signed then squared, to sse_r with the same saturation rules.
- DIV_ERR_REM_EN not defined:
  - The sse_r port and its accumulator are absent.
  - r_apx is accepted but unused.

## Structure
- Package div_err_pkg holds:
  - the state enum (IDLE, DIV, ACC);
  - the constants N_W=16, D_W=8 and ITER=8;
  - a saturating-add function used for every counter and accumulator.
- Sub-module restoring_div_seq contains the 8-cycle exact divider: start/busy/done, q_exact and r_exact. The top level holds the FSM, the handshake and the accumulators.

## Test plan
- After rst, apply n=100, d=7, q_apx=14, r_apx=2 → after 10 cycles: sample_cnt=1, sse_q=0, max_err_q=0, sse_r=0.
- Apply n=100, d=7, q_apx=12, r_apx=16 → sse_q=4, max_err_q=2; with DIV_ERR_REM_EN, sse_r=196.
- Apply n=0x0800, d=8 (overflow) and then d=0 → ovf_cnt=2, sample_cnt unchanged, in_ready back 2 cycles after each accept.
- Hold in_valid high continuously → exactly one accept per 10 cycles, and in_ready is low during DIV and ACC.
- Assert clear on cycle 4 of DIV → all statistics 0, IDLE on the next cycle, and the aborted sample is not counted.
- Preload via 65535 samples with q_apx = q_exact ^ 0xFF where applicable → sat=1, sample_cnt=0xFFFF; a further sample leaves all statistics unchanged.
